muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the integer multiply/divide resource beside the main ALU.
- Owns the HI/LO register pair. Runs MULT/MULTU/DIV/DIVU iteratively (radix-2: shift-add for multiply, restoring for divide). Services MFHI/MFLO/MTHI/MTLO.
- Stalls the issuing stage while busy. Sits in EX next to the ALU and is driven by the same 6-bit funct field.

Parameters:
WIDTH, 32, operand and HI/LO width. Multiple of 2, at least 8.
CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-low
req_valid  input  1  EX holds an R-type instruction whose funct is in the muldiv group
funct  input  6  instruction funct field
op_a  input  WIDTH  rs value (multiplicand / dividend / MT source)
op_b  input  WIDTH  rt value (multiplier / divisor)
flush  input  1  pipeline flush; aborts the in-flight operation
stall  output  1  hold EX/upstream this cycle
busy  output  1  state != IDLE
done  output  1  one-cycle pulse when HI/LO receive an iterative result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
mf_data  output  WIDTH  MFHI→hi, MFLO→lo, else 0; combinational

Behaviour:
- Funct codes:
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011
  - Any other funct with req_valid=1 is ignored: no state change, stall=0.
- Reset (rst=0 at an edge): state=IDLE, hi=0, lo=0, counter=0, working regs=0, done=0. Reset wins over every other input, including mid-operation.
- stall = req_valid & busy (combinational). A request is accepted only in IDLE. The requester holds req_valid/funct/operands until stall=0.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE:
  - MTHI: hi<=op_a. MTLO: lo<=op_a. Both take effect at the next edge, no stall.
  - MFHI/MFLO in IDLE: stall=0.
  - MULT/MULTU:
    - Latch |op_a| and |op_b|; signed only for MULT, raw values for MULTU.
    - Latch result-sign = sign(op_a)^sign(op_b) for MULT, 0 for MULTU.
    - counter<=0, go to MUL.
  - DIV/DIVU:
    - Latch magnitudes the same way.
    - Quotient sign = sign(a)^sign(b). Remainder sign = sign(a).
    - If op_b==0: go straight to FIX with quotient={WIDTH{1}} and remainder=op_a (raw), sign correction disabled.
    - Otherwise counter<=0, go to DIV.
- MUL: one shift-add step per cycle on a 2*WIDTH product register. counter++. After WIDTH steps go to FIX.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). After WIDTH steps go to FIX.
- FIX (1 cycle):
  - Apply two's-complement negation where the latched sign is set.
  - Multiply: {hi,lo}<=product. Divide: lo<=quotient, hi<=remainder.
  - done=1 this cycle. Next state IDLE.
- Latency from accept edge to HI/LO update: WIDTH+2 edges (34 for WIDTH=32). Divide-by-zero takes 2 edges. MFHI issued behind it sees the new value on its first unstalled cycle.
- flush=1 in MUL/DIV/FIX: go to IDLE at the next edge, HI/LO unchanged, no done pulse. flush in IDLE has no effect. A request and a flush in the same IDLE cycle: the flush wins and the request is dropped.
- Signed overflow case MULT 0x80000000 × 0x80000000 = 0x40000000_00000000. DIV 0x80000000 / -1 gives lo=0x80000000, hi=0 (wrap, no trap).

Optional Feature:
- Macro MULDIV_EARLY_EXIT_EN.
- Defined: in MUL, when the remaining un-shifted multiplier bits are all zero, the product is aligned in one step and the FSM goes to FIX. Minimum 1 MUL cycle, so latency = (index of multiplier MSB set)+3, and 3 edges for a zero multiplier. DIV is unaffected.
- Undefined: fixed WIDTH-cycle MUL.

Test Plan:
- Reset: drive rst=0 for 2 cycles mid-DIV → hi=lo=0, busy=0, done=0 after the first reset edge.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 34 edges hi=0xFFFFFFFE, lo=0x00000001, done pulses once; back-to-back MFHI is stalled 34 cycles, then mf_data=0xFFFFFFFE.
- MULT -7 × 3 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 → 2 edges later lo=0xFFFFFFFF, hi=100.
- MTHI 0x1234 then MTLO 0x5678 in consecutive IDLE cycles → no stall, hi=0x1234, lo=0x5678; flush at cycle 10 of a MULTU leaves both values intact, no done pulse.
- With MULDIV_EARLY_EXIT_EN: MULTU 5 × 2 → lo=10 in 4 edges. Without the macro: 34 edges.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/result bundle between EX and the multiply/divide sequencer
interface muldiv_seq_if #(parameter int WIDTH = 32);
    logic             req_valid;
    logic [5:0]       funct;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mf_data;
    modport master (output req_valid, funct, op_a, op_b, flush,
                    input stall, busy, done, hi, lo, mf_data);
    modport slave (input req_valid, funct, op_a, op_b, flush,
                   output stall, busy, done, hi, lo, mf_data);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative radix-2 multiply/divide sequencer owning HI/LO.
// Optional MULDIV_EARLY_EXIT_EN: MUL ends once the remaining multiplier bits are zero.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic clk,
    input logic rst,
    muldiv_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] MTLO  = 6'b010011;
    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIV_F = 6'b011010;
    localparam logic [5:0] DIVU  = 6'b011011;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] p_r;
    logic [2*WIDTH-1:0] a_r;
    logic [WIDTH-1:0]   b_r;
    logic               is_div;
    logic               q_neg;
    logic               r_neg;
    logic               signed_op;
    logic               a_sgn;
    logic               b_sgn;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] p_add;
    logic               cnt_end;
    logic               mul_last;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    // MULT and DIV are the even funct codes of the group
    assign signed_op = ~bus.funct[0];
    assign a_sgn     = signed_op & bus.op_a[WIDTH-1];
    assign b_sgn     = signed_op & bus.op_b[WIDTH-1];
    assign a_mag     = a_sgn ? -bus.op_a : bus.op_a;
    assign b_mag     = b_sgn ? -bus.op_b : bus.op_b;
    // p_r holds {remainder, quotient} while dividing, the running product while multiplying
    assign trial     = p_r[2*WIDTH-1:WIDTH-1] - {1'b0, b_r};
    assign p_add     = p_r + (b_r[0] ? a_r : '0);
    assign cnt_end   = cnt == CNT_W'(WIDTH - 1);
`ifdef MULDIV_EARLY_EXIT_EN
    assign mul_last  = cnt_end || b_r[WIDTH-1:1] == '0;
`else
    assign mul_last  = cnt_end;
`endif
    assign q_fix     = q_neg ? -p_r[WIDTH-1:0] : p_r[WIDTH-1:0];
    assign r_fix     = r_neg ? -p_r[2*WIDTH-1:WIDTH] : p_r[2*WIDTH-1:WIDTH];

    assign bus.busy    = state != IDLE;
    assign bus.stall   = bus.req_valid & bus.busy;
    assign bus.mf_data = bus.funct == MFHI ? bus.hi : bus.funct == MFLO ? bus.lo : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            p_r      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            is_div   <= 1'b0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (bus.flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (bus.req_valid) begin
                        case (bus.funct)
                            MTHI: bus.hi <= bus.op_a;
                            MTLO: bus.lo <= bus.op_a;
                            MULT, MULTU, DIV_F, DIVU: begin
                                is_div <= bus.funct[1];
                                cnt    <= '0;
                                q_neg  <= a_sgn ^ b_sgn;
                                r_neg  <= a_sgn;
                                a_r    <= {{WIDTH{1'b0}}, a_mag};
                                b_r    <= b_mag;
                                p_r    <= bus.funct[1] ? {{WIDTH{1'b0}}, a_mag} : '0;
                                state  <= bus.funct[1] ? DIV : MUL;
                                if (bus.funct[1] && bus.op_b == '0) begin
                                    p_r   <= {bus.op_a, {WIDTH{1'b1}}};
                                    q_neg <= 1'b0;
                                    r_neg <= 1'b0;
                                    state <= FIX;
                                end
                            end
                            default: ;
                        endcase
                    end
                    MUL: begin
                        p_r   <= p_add;
                        a_r   <= a_r << 1;
                        b_r   <= b_r >> 1;
                        cnt   <= cnt + CNT_W'(1);
                        state <= mul_last ? FIX : MUL;
                    end
                    DIV: begin
                        p_r   <= trial[WIDTH] ? {p_r[2*WIDTH-2:0], 1'b0}
                                              : {trial[WIDTH-1:0], p_r[WIDTH-2:0], 1'b1};
                        cnt   <= cnt + CNT_W'(1);
                        state <= cnt_end ? FIX : DIV;
                    end
                    FIX: begin
                        if (is_div) begin
                            bus.lo <= q_fix;
                            bus.hi <= r_fix;
                        end else begin
                            {bus.hi, bus.lo} <= q_neg ? -p_r : p_r;
                        end
                        bus.done <= 1'b1;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed checks of muldiv_seq against an arithmetic model
module tb_muldiv_seq;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] MTLO  = 6'b010011;
    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIV_F = 6'b011010;
    localparam logic [5:0] DIVU  = 6'b011011;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   fails = 0;

    muldiv_seq_if #(.WIDTH(32)) bus ();
    muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] e, output int lat);
        longint sa, sb, q, r;
        logic [31:0] m;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lat = 34;
        e = '0;
        case (f)
            MULT:  e = sa * sb;
            MULTU: e = {32'b0, a} * {32'b0, b};
            DIV_F: if (b == 0) begin e = {a, 32'hFFFFFFFF}; lat = 2; end
                   else begin q = sa / sb; r = sa % sb; e = {r[31:0], q[31:0]}; end
            DIVU:  if (b == 0) begin e = {a, 32'hFFFFFFFF}; lat = 2; end
                   else e = {a % b, a / b};
            default: ;
        endcase
`ifdef MULDIV_EARLY_EXIT_EN
        if (f == MULT || f == MULTU) begin
            m = (f == MULT && b[31]) ? -b : b;
            lat = 3;
            for (int i = 0; i < 32; i++) if (m[i]) lat = i + 3;
        end
`else
        m = '0;
`endif
    endtask

    // Starts #1 after a rising edge, ends #1 after the edge following the done pulse
    task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic mf);
        logic [63:0] e;
        int lat, n;
        model(f, a, b, e, lat);
        bus.req_valid = 1'b1; bus.funct = f; bus.op_a = a; bus.op_b = b;
        #1 check("accept_stall", bus.stall, 0);
        @(posedge clk); #1;
        n = 1;
        bus.req_valid = mf; bus.funct = MFHI; bus.op_a = $urandom; bus.op_b = $urandom;
        #1;
        check("busy", bus.busy, 1);
        if (mf) check("mf_stalled", bus.stall, 1);
        while (!bus.done && n < 100) begin @(posedge clk); #1; n++; end
        check("latency", n, lat);
        check("hi", bus.hi, e[63:32]);
        check("lo", bus.lo, e[31:0]);
        if (mf) begin
            check("mf_released", bus.stall, 0);
            check("mfhi", bus.mf_data, e[63:32]);
        end
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("done_once", bus.done, 0);
    endtask

    initial begin
        int dn;
        bus.req_valid = 1'b0; bus.funct = '0; bus.op_a = '0; bus.op_b = '0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        do_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        do_op(MULT, -32'sd7, 32'd3, 1'b0);
        do_op(DIV_F, -32'sd7, 32'd2, 1'b0);
        do_op(DIVU, 32'd100, 32'd0, 1'b1);
        do_op(MULT, 32'h80000000, 32'h80000000, 1'b0);
        do_op(DIV_F, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        do_op(MULTU, 32'd5, 32'd2, 1'b0);
        do_op(MULT, 32'd9, 32'd0, 1'b0);
        do_op(DIV_F, 32'd7, -32'sd2, 1'b1);

        bus.req_valid = 1'b1; bus.funct = MTHI; bus.op_a = 32'h1234;
        #1 check("mthi_stall", bus.stall, 0);
        @(posedge clk); #1;
        bus.funct = MTLO; bus.op_a = 32'h5678;
        #1 check("mtlo_stall", bus.stall, 0);
        @(posedge clk); #1;
        bus.funct = MFLO;
        #1 check("mflo", bus.mf_data, 32'h5678);
        bus.funct = MFHI;
        #1 check("mfhi_idle", bus.mf_data, 32'h1234);
        bus.funct = 6'b000000; bus.op_a = 32'hDEAD;
        #1 check("other_stall", bus.stall, 0);
        check("other_mf", bus.mf_data, 0);
        @(posedge clk); #1;
        check("other_busy", bus.busy, 0);
        check("other_hi", bus.hi, 32'h1234);

        bus.funct = MTHI; bus.op_a = 32'hBEEF; bus.flush = 1'b1;
        @(posedge clk); #1;
        check("flush_drop_hi", bus.hi, 32'h1234);
        bus.funct = MULTU;
        @(posedge clk); #1;
        check("flush_drop_busy", bus.busy, 0);
        bus.flush = 1'b0;

        bus.funct = MULTU; bus.op_a = 32'd77; bus.op_b = 32'hFFFF0001;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_busy", bus.busy, 0);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            dn += int'(bus.done);
            @(posedge clk); #1;
        end
        check("flush_no_done", dn, 0);
        check("flush_hi", bus.hi, 32'h1234);
        check("flush_lo", bus.lo, 32'h5678);

        bus.req_valid = 1'b1; bus.funct = DIVU; bus.op_a = 32'd1000; bus.op_b = 32'd3;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_hi", bus.hi, 0);
        check("midrst_lo", bus.lo, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            logic [5:0] f;
            logic [31:0] a, b;
            f = {4'b0110, 2'($urandom_range(0, 3))};
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) b = '0;
            do_op(f, a, b, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
